// File: rtl/txbuf_pkg.sv
// Shared definitions for the loopback transmit buffer.
// Holds the default frame length, the derived byte count, the address and
// bit-counter widths, and the drain/capture state encoding.
package txbuf_pkg;

  localparam int unsigned NBITS_DEF = 10000;
  localparam int unsigned NBYTES    = NBITS_DEF / 8;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned CNT_W     = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_RD,
    ST_LOAD,
    ST_WAIT_LO,
    ST_WAIT_HI
  } state_t;

endpackage

// File: rtl/txmitbuffer_if.sv
// Handshake bundle between the loopback receiver / UART and txmitbuffer.
//   bit_tick  : one-cycle bit-rate enable
//   start     : asynchronous frame marker (high while a frame streams)
//   databit   : serial loopback data, LSB of each byte first
//   tbre      : UART transmit holding register empty
//   thr, wrn  : byte to the UART and its one-cycle load strobe
//   tx_full, tx_empty, frame_err : buffer status
// master = environment side, slave = txmitbuffer side.
interface txmitbuffer_if;

  logic       bit_tick;
  logic       start;
  logic       databit;
  logic       tbre;
  logic [7:0] thr;
  logic       wrn;
  logic       tx_full;
  logic       tx_empty;
  logic       frame_err;

  modport master (
    output bit_tick, start, databit, tbre,
    input  thr, wrn, tx_full, tx_empty, frame_err
  );

  modport slave (
    input  bit_tick, start, databit, tbre,
    output thr, wrn, tx_full, tx_empty, frame_err
  );

endinterface

// File: rtl/txbuf_ram.sv
// Frame storage: DEPTH x 8 simple dual-port RAM.
//   clk          : clock
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : synchronous read port, one cycle latency
// No reset: contents are always rewritten by a complete capture before read.
module txbuf_ram #(
  parameter int unsigned DEPTH  = 1250,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/txmitbuffer.sv
// Loopback transmit buffer.
// Captures one frame of NBITS serial bits (LSB-first bytes) into a RAM while
// start is high, then drains it byte by byte to a UART transmit holding
// register using the tbre/wrn handshake.
//   txbuf_clk : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : txmitbuffer_if.slave handshake bundle
module txmitbuffer
  import txbuf_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF
) (
  input  logic          txbuf_clk,
  input  logic          reset_n,
  txmitbuffer_if.slave  bus
);

  localparam int unsigned       FRAME_BYTES = NBITS / 8;
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(NBITS - 1);
  localparam logic [ADDR_W-1:0] END_ADDR    = ADDR_W'(FRAME_BYTES);

  state_t state, state_nxt;

  logic              start_s1, start_s2, start_d;
  logic              start_rise, start_fall;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]        shreg, byte_nxt;
  logic [7:0]        thr_hold, ram_q;
  logic              tx_full, tx_empty, frame_err;

  logic clr_frame, cap_bit, ram_we, ram_re, set_full, drain_done, set_err;

  assign start_rise = start_s2 & ~start_d;
  assign start_fall = ~start_s2 & start_d;

  // Assembly register with the current bit merged in, so the byte completed
  // by the 8th tick can be written to RAM in that same cycle.
  always_comb begin
    byte_nxt = shreg;
    byte_nxt[bit_cnt[2:0]] = bus.databit;
  end

  always_ff @(posedge txbuf_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    clr_frame  = 1'b0;
    cap_bit    = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    set_full   = 1'b0;
    drain_done = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          clr_frame = 1'b1;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bus.bit_tick) begin
          cap_bit = 1'b1;
          ram_we  = (bit_cnt[2:0] == 3'd7);
        end
        // A tick that completes the frame takes precedence over a coincident
        // start fall: the frame is whole, so there is nothing to abort.
        if (bus.bit_tick && bit_cnt == LAST_BIT) begin
          set_full  = 1'b1;
          state_nxt = ST_RD;
        end else if (start_fall) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        if (bus.tbre) begin
          ram_re    = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!bus.tbre) state_nxt = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (bus.tbre) begin
          if (rd_addr == END_ADDR) begin
            drain_done = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            state_nxt = ST_RD;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start_rise && state != ST_IDLE) set_err = 1'b1;
  end

  always_ff @(posedge txbuf_clk or negedge reset_n) begin
    if (!reset_n) begin
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
      start_d   <= 1'b0;
      bit_cnt   <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      shreg     <= '0;
      thr_hold  <= '0;
      tx_full   <= 1'b0;
      tx_empty  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      start_s1 <= bus.start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
      if (clr_frame) begin
        bit_cnt  <= '0;
        wr_addr  <= '0;
        shreg    <= '0;
        tx_empty <= 1'b0;
      end
      if (cap_bit) begin
        shreg   <= byte_nxt;
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt[2:0] == 3'd7) wr_addr <= wr_addr + 1'b1;
      end
      if (set_full) begin
        tx_full <= 1'b1;
        rd_addr <= '0;
      end
      if (state == ST_LOAD) begin
        thr_hold <= ram_q;
        rd_addr  <= rd_addr + 1'b1;
      end
      if (drain_done) begin
        tx_full  <= 1'b0;
        tx_empty <= 1'b1;
      end
      if (set_err) frame_err <= 1'b1;
    end
  end

  txbuf_ram #(
    .DEPTH  (FRAME_BYTES),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (txbuf_clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (byte_nxt),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // RAM data is valid only during LOAD; thr_hold keeps it visible afterwards.
  assign bus.thr       = (state == ST_LOAD) ? ram_q : thr_hold;
  assign bus.wrn       = (state == ST_LOAD);
  assign bus.tx_full   = tx_full;
  assign bus.tx_empty  = tx_empty;
  assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_txmitbuffer.sv
module tb_txmitbuffer;

  logic clk;
  logic rst_n;

  txmitbuffer_if bus ();

  txmitbuffer dut (
    .txbuf_clk (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         wrn_cnt   = 0;
  int         slow_n    = 0;
  int         busy_left = 0;
  int         gap       = 0;
  bit         gap_on    = 1'b0;
  logic [7:0] first_thr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor, scoreboard pop and UART tbre model in one process so that
  // the tbre level seen by the wrn check is never racing the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!bus.tx_full) gap_on = 1'b0;
      if (gap_on) gap++;
      if (bus.wrn) begin
        chk("wrn_tbre_hi", bus.tbre, 1);
        if (gap_on) chk("tbre_to_wrn_le8", (gap <= 8), 1);
        gap_on = 1'b0;
        if (wrn_cnt == 0) first_thr = bus.thr;
        if (exp_q.size() == 0) chk("wrn_extra", exp_q.size(), 1);
        else                   chk("thr", bus.thr, exp_q.pop_front());
        wrn_cnt++;
        busy_left = (wrn_cnt <= slow_n) ? 500 : 2;
        bus.tbre = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          bus.tbre = 1'b1;
          gap      = 0;
          gap_on   = 1'b1;
        end
      end
    end
  end

  task automatic send_frame(input int nbits, input int base, input bit keep);
    logic [7:0] b;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = 8'(((i / 8) + base) % 256);
      if (i % 97 == 50) begin
        bus.bit_tick = 1'b0;
        bus.databit  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.bit_tick = 1'b1;
      bus.databit  = b[i % 8];
      if (keep && (i % 8 == 7)) exp_q.push_back(b);
      @(negedge clk);
    end
    bus.bit_tick = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    int n = 0;
    while (wrn_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (wrn_cnt >= target), 1);
  endtask

  task automatic wait_empty(input int budget, input string tag);
    int n = 0;
    while (!bus.tx_empty && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.tx_empty, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.bit_tick = 1'b0;
    bus.databit  = 1'b0;
    bus.tbre     = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_thr", bus.thr, 0);
    chk("rst_wrn", bus.wrn, 0);
    chk("rst_tx_full", bus.tx_full, 0);
    chk("rst_tx_empty", bus.tx_empty, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Frame A: byte k = k mod 256, fast UART, start re-raised mid-drain.
    wrn_cnt = 0;
    slow_n  = 0;
    send_frame(10000, 0, 1'b1);
    repeat (2) @(negedge clk);
    chk("a_tx_full", bus.tx_full, 1);
    chk("a_err_before", bus.frame_err, 0);
    wait_bytes(300, 20000, "a_reach300");
    bus.start = 1'b1;
    repeat (8) @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("a_err_restart", bus.frame_err, 1);
    chk("a_full_mid", bus.tx_full, 1);
    wait_empty(20000, "a_drain_done");
    chk("a_nbytes", wrn_cnt, 1250);
    chk("a_q_left", exp_q.size(), 0);
    chk("a_tx_full_end", bus.tx_full, 0);
    repeat (20) @(negedge clk);
    chk("a_empty_holds", bus.tx_empty, 1);
    chk("a_thr_hold", bus.thr, 8'hE1);
    chk("a_wrn_idle", bus.wrn, 0);

    // Short frame after a clean reset.
    pulse_reset();
    chk("s_err_cleared", bus.frame_err, 0);
    wrn_cnt = 0;
    send_frame(4000, 0, 1'b0);
    repeat (10) @(negedge clk);
    chk("s_frame_err", bus.frame_err, 1);
    chk("s_tx_full", bus.tx_full, 0);
    chk("s_tx_empty", bus.tx_empty, 0);
    repeat (50) @(negedge clk);
    chk("s_no_wrn", wrn_cnt, 0);

    // Frame B: byte k = (k+1) mod 256, slow UART for 20 bytes, reset at 600.
    wrn_cnt = 0;
    slow_n  = 20;
    send_frame(10000, 1, 1'b1);
    wait_bytes(600, 60000, "b_reach600");
    chk("b_first_byte", first_thr, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("b_rst_thr", bus.thr, 0);
    chk("b_rst_wrn", bus.wrn, 0);
    chk("b_rst_tx_full", bus.tx_full, 0);
    chk("b_rst_tx_empty", bus.tx_empty, 0);
    chk("b_rst_frame_err", bus.frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    slow_n  = 0;
    wrn_cnt = 0;

    // Frame C: byte k = (k+7) mod 256 after the mid-drain reset.
    send_frame(10000, 7, 1'b1);
    wait_empty(20000, "c_drain_done");
    chk("c_nbytes", wrn_cnt, 1250);
    chk("c_q_left", exp_q.size(), 0);
    chk("c_tx_full_end", bus.tx_full, 0);
    chk("c_frame_err", bus.frame_err, 0);
    repeat (5) @(negedge clk);
    chk("c_thr_hold", bus.thr, 8'hE8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
